// File: rtl/cdec8_res_monitor_pkg.sv
// Shared constants for the CDEC8 resource monitor.
// Holds the frame header byte, the default resource count, the UART
// character length and the monitor FSM state encoding.
package cdec8_res_monitor_pkg;

  localparam logic [7:0] MON_FRAME_HDR = 8'hA5;
  localparam int         MON_NUM_RES   = 16;
  // start bit + 8 data bits + stop bit
  localparam int         MON_UART_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN_SET = 2'd1,
    ST_SCAN_CAP = 2'd2,
    ST_TX_BYTE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/cdec8_res_monitor_uart_tx8.sv
// uart_tx8: 8N1 serial transmitter, LSB first, idle high.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start          load data and begin a character (accepted when idle or in the done cycle)
//   data[7:0]      character to send, sampled on an accepted start
//   busy           character in progress
//   done           one-cycle pulse in the last cycle of the stop bit
//   txd            serial output
module uart_tx8
  import cdec8_res_monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BITS_LOAD = 4'(MON_UART_BITS - 1);

  logic          busy_q;
  logic [9:0]    frame_q;
  logic [CW-1:0] baud_cnt_q;
  logic [3:0]    bits_left_q;
  logic          baud_tc;
  logic          load;

  assign baud_tc = (baud_cnt_q == '0);
  assign done    = busy_q && baud_tc && (bits_left_q == 4'd0);
  // A start in the done cycle chains the next character with no idle gap.
  assign load    = start && (!busy_q || done);
  assign busy    = busy_q;
  assign txd     = frame_q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= 1'b0;
      frame_q     <= '1;
      baud_cnt_q  <= '0;
      bits_left_q <= 4'd0;
    end else if (load) begin
      busy_q      <= 1'b1;
      frame_q     <= {1'b1, data, 1'b0};
      baud_cnt_q  <= BAUD_LOAD;
      bits_left_q <= BITS_LOAD;
    end else if (busy_q) begin
      if (baud_tc) begin
        baud_cnt_q <= BAUD_LOAD;
        if (bits_left_q == 4'd0) begin
          busy_q <= 1'b0;
        end else begin
          bits_left_q <= bits_left_q - 4'd1;
          // Shift in ones so the line rests high once the stop bit is out.
          frame_q     <= {1'b1, frame_q[9:1]};
        end
      end else begin
        baud_cnt_q <= baud_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdec8_res_monitor.sv
// cdec8_res_monitor: scans the CDEC8 observation bus and ships a snapshot
// to the PC debug monitor as one framed, checksummed UART packet.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   resad          resource address driven to the data path
//   resdt          resource data returned for resad
//   snap_req       one-cycle request to take a snapshot
//   busy           snapshot/frame in progress
//   frame_done     one-cycle pulse after the final stop bit
//   txd            UART serial output
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for snap_req or auto trigger
// ST_SCAN_SET | drive resad <= idx
// ST_SCAN_CAP | capture resdt into snap_buf[idx], accumulate checksum
// ST_TX_BYTE  | send header, snap_buf[0..NUM_RES-1], checksum
module cdec8_res_monitor
  import cdec8_res_monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_RES      = MON_NUM_RES,
  parameter int AUTO_PERIOD  = 0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  input  logic       snap_req,
  output logic       busy,
  output logic       frame_done,
  output logic       txd
);

  localparam int IW = $clog2(NUM_RES) + 1;
  localparam int AW = $clog2(NUM_RES);
  localparam int TW = $clog2(NUM_RES + 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RES - 1);
  localparam logic [TW-1:0] LAST_BYTE = TW'(NUM_RES + 1);

  mon_state_t    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tx_cnt_q;
  logic [7:0]    chk_q;
  logic [7:0]    resad_q;
  logic          frame_done_q;
  logic [31:0]   auto_cnt_q;
  logic [7:0]    snap_buf [NUM_RES];

  logic          accept;
  logic          auto_fire;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [TW-1:0] byte_sel;
  logic [AW-1:0] rd_addr;
  logic          uart_busy;
  logic          uart_done;

  assign auto_fire  = (auto_cnt_q == 32'd1);
  // A request landing in the frame_done cycle is dropped on purpose.
  assign accept     = (state_q == ST_IDLE) && !frame_done_q && (snap_req || auto_fire);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign resad      = resad_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SCAN_SET;
      end
      ST_SCAN_SET: begin
        state_d = ST_SCAN_CAP;
      end
      ST_SCAN_CAP: begin
        if (idx_q == LAST_IDX) begin
          state_d  = ST_TX_BYTE;
          tx_start = 1'b1;
        end else begin
          state_d = ST_SCAN_SET;
        end
      end
      ST_TX_BYTE: begin
        if (uart_done) begin
          if (tx_cnt_q == LAST_BYTE) state_d = ST_IDLE;
          else                       tx_start = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte 0 is the header, 1..NUM_RES the buffer, NUM_RES+1 the checksum.
  // The header is launched from the last capture cycle, so select 0 there.
  always_comb begin
    byte_sel = (state_q == ST_SCAN_CAP) ? '0 : tx_cnt_q + 1'b1;
    rd_addr  = AW'(byte_sel - 1'b1);
    if (byte_sel == '0)            tx_data = MON_FRAME_HDR;
    else if (byte_sel == LAST_BYTE) tx_data = chk_q;
    else                           tx_data = snap_buf[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q        <= '0;
      tx_cnt_q     <= '0;
      chk_q        <= 8'h00;
      resad_q      <= 8'h00;
      frame_done_q <= 1'b0;
      auto_cnt_q   <= 32'd0;
    end else begin
      frame_done_q <= (state_q == ST_TX_BYTE) && uart_done && (tx_cnt_q == LAST_BYTE);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q      <= '0;
            chk_q      <= 8'h00;
            auto_cnt_q <= 32'd0;
          end else if (!frame_done_q && (auto_cnt_q != 32'd0)) begin
            auto_cnt_q <= auto_cnt_q - 32'd1;
          end
        end
        ST_SCAN_SET: begin
          resad_q <= 8'(idx_q);
        end
        ST_SCAN_CAP: begin
          chk_q <= chk_q + resdt;
          if (idx_q == LAST_IDX) tx_cnt_q <= '0;
          else                   idx_q    <= idx_q + 1'b1;
        end
        ST_TX_BYTE: begin
          if (uart_done) begin
            if (tx_cnt_q == LAST_BYTE) begin
              resad_q <= 8'h00;
              if (AUTO_PERIOD != 0) auto_cnt_q <= 32'(AUTO_PERIOD);
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_SCAN_CAP) snap_buf[idx_q[AW-1:0]] <= resdt;
  end

  uart_tx8 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx8 (
    .clock (clock),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .busy  (uart_busy),
    .done  (uart_done),
    .txd   (txd)
  );

endmodule

// File: tb/tb_cdec8_res_monitor.sv
// Directed bench for cdec8_res_monitor with CLKS_PER_BIT=4, NUM_RES=16.
module tb_cdec8_res_monitor;

  localparam int CPB    = 4;
  localparam int NB     = 18;
  localparam int FRAMEC = NB * 10 * CPB;

  logic       clock;
  logic       reset;
  logic [7:0] resad;
  logic [7:0] resdt;
  logic       snap_req;
  logic       busy;
  logic       frame_done;
  logic       txd;

  bit model_ff;
  int checks;
  int errors;
  int fd_count;

  cdec8_res_monitor #(
    .CLKS_PER_BIT(CPB),
    .NUM_RES(16),
    .AUTO_PERIOD(0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .resad     (resad),
    .resdt     (resdt),
    .snap_req  (snap_req),
    .busy      (busy),
    .frame_done(frame_done),
    .txd       (txd)
  );

  assign resdt = model_ff ? 8'hFF : resad + 8'h10;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (frame_done === 1'b1) fd_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with snap_req driven high; returns at the
  // negedge inside the frame_done cycle.
  task automatic run_frame(input string tag, input bit ff, input bit extra,
                           input logic [7:0] exp_chk);
    logic [7:0] exp_bytes [NB];
    logic       wave [FRAMEC];
    logic [7:0] rx;
    logic       eb;
    int         bad;
    int         shape_bad;
    exp_bytes[0] = 8'hA5;
    for (int k = 0; k < 16; k++) exp_bytes[k+1] = ff ? 8'hFF : 8'(8'h10 + k);
    exp_bytes[NB-1] = exp_chk;
    model_ff = ff;

    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);

    bad = 0;
    for (int c = 2; c <= 33; c++) begin
      @(negedge clock);
      if (resad !== 8'((c - 2) / 2) || busy !== 1'b1 || frame_done !== 1'b0) bad++;
      snap_req = extra && (c == 10);
    end
    check({tag, "_scan_timing"}, bad, 0);

    bad = 0;
    for (int i = 0; i < FRAMEC; i++) begin
      if (i > 0) @(negedge clock);
      wave[i] = txd;
      if (busy !== 1'b1 || frame_done !== 1'b0) bad++;
      snap_req = extra && (i == 300);
    end
    snap_req = 1'b0;
    check({tag, "_busy_during_tx"}, bad, 0);

    shape_bad = 0;
    for (int b = 0; b < NB; b++) begin
      rx = 8'h00;
      for (int j = 0; j < 10; j++) begin
        if (j == 0)      eb = 1'b0;
        else if (j == 9) eb = 1'b1;
        else             eb = exp_bytes[b][j-1];
        for (int q = 0; q < CPB; q++)
          if (wave[b*40 + j*CPB + q] !== eb) shape_bad++;
        if (j >= 1 && j <= 8) rx[j-1] = wave[b*40 + j*CPB + 2];
      end
      check($sformatf("%s_byte%0d", tag, b), rx, exp_bytes[b]);
    end
    check({tag, "_bit_shape"}, shape_bad, 0);
    check({tag, "_start_bit0"}, {wave[0], wave[1], wave[2], wave[3], wave[4]}, 5'b00001);
    check({tag, "_stop_bit0"}, {wave[35], wave[36], wave[37], wave[38], wave[39], wave[40]},
          {exp_bytes[0][7], 5'b11110});

    @(negedge clock);
    check({tag, "_frame_done"}, frame_done, 1);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_resad_idle"}, resad, 8'h00);
    check({tag, "_txd_idle"}, txd, 1);
  endtask

  initial begin
    int fd0;
    int bad;
    checks   = 0;
    errors   = 0;
    fd_count = 0;
    model_ff = 1'b0;
    reset    = 1'b1;
    snap_req = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rst%0d_txd", i), txd, 1);
      check($sformatf("rst%0d_resad", i), resad, 8'h00);
      check($sformatf("rst%0d_busy", i), busy, 0);
      check($sformatf("rst%0d_frame_done", i), frame_done, 0);
    end
    reset = 1'b0;
    @(negedge clock);

    fd0 = fd_count;
    run_frame("ramp", 1'b0, 1'b0, 8'h78);

    // Request one cycle after frame_done must be accepted.
    @(negedge clock);
    run_frame("ffx", 1'b1, 1'b1, 8'hF0);

    // Request in the frame_done cycle must be dropped.
    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || txd !== 1'b1) bad++;
      @(negedge clock);
    end
    check("fd_cycle_req_ignored", bad, 0);
    check("frame_count", fd_count - fd0, 2);

    // Reset while byte 5 data bits are on the line.
    model_ff = 1'b0;
    snap_req = 1'b1;
    @(negedge clock);
    snap_req = 1'b0;
    repeat (32 + 210) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_resad", resad, 8'h00);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy !== 1'b0 || txd !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    check("midrst_no_resume", bad, 0);
    run_frame("post_rst", 1'b0, 1'b0, 8'h78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
